// File: rtl/arith_pipe_nbit.sv
// Pipelined N-bit adder/subtractor: the carry chain is cut into STAGES segments of N/STAGES bits,
// one register stage per segment, with a single global stall enable for valid/ready flow control.
module arith_pipe_nbit #(
  parameter int N      = 16,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  output logic         ready_out,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic         sub_in,
  output logic         valid_out,
  input  logic         ready_in,
  output logic [N-1:0] sum_out,
  output logic         carry_out,
  output logic         ovf_out
);

  localparam int W = N / STAGES;

  logic [N-1:0]      a_s   [STAGES];
  logic [N-1:0]      b_s   [STAGES];
  logic [N-1:0]      sum_s [STAGES];
  logic [STAGES-1:0] carry_s;
  logic [STAGES-1:0] valid_s;
  logic              ovf_s;
  logic              en;

  // Whole pipe advances together; bubbles are held in place while stalled.
  assign en        = ready_in | ~valid_s[STAGES-1];
  assign ready_out = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [N-1:0] a_i, b_i, s_i;
    logic         c_i, v_i;
    logic [W:0]   seg;
    logic [N-1:0] a_d, a_q, b_d, b_q, sum_d, sum_q;
    logic         carry_d, carry_q, valid_d, valid_q;

    if (k == 0) begin : g_src
      // Subtract as A + ~B + 1: invert B up front, sub_in is the stage-0 carry-in.
      assign a_i = a_in;
      assign b_i = b_in ^ {N{sub_in}};
      assign s_i = '0;
      assign c_i = sub_in;
      assign v_i = valid_in;
    end else begin : g_src
      assign a_i = a_s[k-1];
      assign b_i = b_s[k-1];
      assign s_i = sum_s[k-1];
      assign c_i = carry_s[k-1];
      assign v_i = valid_s[k-1];
    end

    always_comb begin
      seg     = {1'b0, a_i[k*W +: W]} + {1'b0, b_i[k*W +: W]} + (W+1)'(c_i);
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      valid_d = valid_q;
      if (en) begin
        valid_d = v_i;
        if (v_i) begin
          a_d               = a_i;
          a_d[k*W +: W]     = '0;
          b_d               = b_i;
          b_d[k*W +: W]     = '0;
          sum_d             = s_i;
          sum_d[k*W +: W]   = seg[W-1:0];
          carry_d           = seg[W];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_q     <= '0;
        b_q     <= '0;
        sum_q   <= '0;
        carry_q <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        a_q     <= a_d;
        b_q     <= b_d;
        sum_q   <= sum_d;
        carry_q <= carry_d;
        valid_q <= valid_d;
      end
    end

    assign a_s[k]     = a_q;
    assign b_s[k]     = b_q;
    assign sum_s[k]   = sum_q;
    assign carry_s[k] = carry_q;
    assign valid_s[k] = valid_q;

    if (k == STAGES - 1) begin : g_ovf
      logic ovf_d, ovf_q;
      logic c_msb;

      // Carry into the MSB recovered from the MSB sum bit and its operand bits.
      assign c_msb = a_i[N-1] ^ b_i[N-1] ^ seg[W-1];

      always_comb begin
        ovf_d = ovf_q;
        if (en && v_i) ovf_d = c_msb ^ seg[W];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
      end

      assign ovf_s = ovf_q;
    end
  end

  assign valid_out = valid_s[STAGES-1];
  assign sum_out   = sum_s[STAGES-1];
  assign carry_out = carry_s[STAGES-1];
  assign ovf_out   = ovf_s;

endmodule

// File: tb/tb_arith_pipe_nbit.sv
// Scoreboard bench for arith_pipe_nbit: three instances (16/4, 8/1, 32/8) share one operand bus,
// expectations come from a plain-arithmetic model and are checked by a decoupled monitor.
module tb_arith_pipe_nbit;

  typedef logic [33:0] exp_t;  // {ovf, carry, sum}

  localparam int NW [3] = '{16, 8, 32};
  localparam int SW [3] = '{4, 1, 8};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  vin = '0;
  logic [2:0]  rin = '1;
  logic [2:0]  rout, vout, cout, ovf;
  logic [31:0] a_drv = '0, b_drv = '0;
  logic        sub_drv = 1'b0;
  logic [15:0] s0;
  logic [7:0]  s1;
  logic [31:0] s2;
  logic [31:0] sum_w [3];

  int n_chk = 0, n_fail = 0, cyc = 0;
  int deliv [3] = '{0, 0, 0};
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arith_pipe_nbit #(.N(16), .STAGES(4)) dut0 (
    .clk(clk), .rst(rst), .valid_in(vin[0]), .ready_out(rout[0]),
    .a_in(a_drv[15:0]), .b_in(b_drv[15:0]), .sub_in(sub_drv),
    .valid_out(vout[0]), .ready_in(rin[0]), .sum_out(s0),
    .carry_out(cout[0]), .ovf_out(ovf[0]));

  arith_pipe_nbit #(.N(8), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .valid_in(vin[1]), .ready_out(rout[1]),
    .a_in(a_drv[7:0]), .b_in(b_drv[7:0]), .sub_in(sub_drv),
    .valid_out(vout[1]), .ready_in(rin[1]), .sum_out(s1),
    .carry_out(cout[1]), .ovf_out(ovf[1]));

  arith_pipe_nbit #(.N(32), .STAGES(8)) dut2 (
    .clk(clk), .rst(rst), .valid_in(vin[2]), .ready_out(rout[2]),
    .a_in(a_drv), .b_in(b_drv), .sub_in(sub_drv),
    .valid_out(vout[2]), .ready_in(rin[2]), .sum_out(s2),
    .carry_out(cout[2]), .ovf_out(ovf[2]));

  assign sum_w[0] = {16'h0, s0};
  assign sum_w[1] = {24'h0, s1};
  assign sum_w[2] = s2;

  // Reference: unsigned sum modulo 2^n, carry = unsigned carry / no-borrow, ovf = signed result out of range.
  function automatic exp_t model(int n, logic [31:0] a, logic [31:0] b, logic sub);
    longint unsigned mask, ua, ub, r;
    longint sa, sb, sr, hi, lo;
    logic c;
    mask = (64'd1 << n) - 1;
    ua   = {32'h0, a} & mask;
    ub   = {32'h0, b} & mask;
    hi   = (longint'(1) <<< (n - 1)) - 1;
    lo   = -(longint'(1) <<< (n - 1));
    sa   = ua[n-1] ? longint'(ua) - (longint'(1) <<< n) : longint'(ua);
    sb   = ub[n-1] ? longint'(ub) - (longint'(1) <<< n) : longint'(ub);
    if (!sub) begin
      r  = ua + ub;
      c  = ((r >> n) & 64'd1) != 0;
      sr = sa + sb;
    end else begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end
    return {(sr > hi) || (sr < lo), c, 32'(r & mask)};
  endfunction

  function automatic int qsize(int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Monitor: record accepted beats, pop and compare delivered beats.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      for (int d = 0; d < 3; d++) begin
        exp_t e, got;
        if (vin[d] && rout[d]) begin
          e = model(NW[d], a_drv, b_drv, sub_drv);
          case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
          endcase
        end
        if (vout[d] && rin[d]) begin
          got = {ovf[d], cout[d], sum_w[d]};
          deliv[d]++;
          n_chk++;
          if (qsize(d) == 0) begin
            n_fail++;
            $display("FAIL dut%0d_unexpected_beat: got %h, expected no beat", d, got);
          end else begin
            case (d)
              0:       e = q0.pop_front();
              1:       e = q1.pop_front();
              default: e = q2.pop_front();
            endcase
            if (got !== e) begin
              n_fail++;
              $display("FAIL dut%0d_result: got %h, expected %h (t=%0t)", d, got, e, $time);
            end
          end
        end
      end
    end
  end

  task automatic send(int d, logic [31:0] a, logic [31:0] b, logic s, output int acc);
    int k = 0;
    a_drv   = a;
    b_drv   = b;
    sub_drv = s;
    vin[d]  = 1'b1;
    @(negedge clk);
    while (!rout[d] && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!rout[d]) chk($sformatf("dut%0d_accept_timeout", d), 64'(rout[d]), 64'd1);
    @(posedge clk);
    #1;
    acc    = cyc;
    vin[d] = 1'b0;
  endtask

  task automatic drain(int d);
    int k = 0;
    while (qsize(d) != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    chk($sformatf("dut%0d_drained", d), 64'(qsize(d)), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic directed(int d, logic [31:0] a, logic [31:0] b, logic s, exp_t exp);
    int acc, k;
    send(d, a, b, s, acc);
    k = 0;
    @(negedge clk);
    while (!vout[d] && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("dut%0d_latency", d), 64'(cyc - acc), 64'(SW[d] - 1));
    chk($sformatf("dut%0d_directed", d), 64'({ovf[d], cout[d], sum_w[d]}), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic random_run(int d, int nbeats);
    logic done;
    int   acc;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < nbeats; i++) begin
          logic [31:0] a, b;
          case ($urandom % 8)
            0:       a = 32'hFFFF_FFFF;
            1:       a = 32'h0;
            default: a = $urandom;
          endcase
          case ($urandom % 8)
            0:       b = 32'hFFFF_FFFF;
            1:       b = 32'h1;
            default: b = $urandom;
          endcase
          send(d, a, b, 1'($urandom % 2), acc);
          if ($urandom % 6 == 0) begin
            repeat ($urandom % 3 + 1) @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          rin[d] = ($urandom % 4) != 0;
        end
        rin[d] = 1'b1;
      end
    join
    drain(d);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc, base;
    logic [31:0] mask32, half, mn, mx;
    exp_t        cap;

    // Reset state, during and after reset
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("dut%0d_rst_valid", d), 64'(vout[d]), 64'd0);
      chk($sformatf("dut%0d_rst_sum", d), 64'(sum_w[d]), 64'd0);
      chk($sformatf("dut%0d_rst_carry", d), 64'(cout[d]), 64'd0);
      chk($sformatf("dut%0d_rst_ovf", d), 64'(ovf[d]), 64'd0);
      chk($sformatf("dut%0d_rst_ready", d), 64'(rout[d]), 64'd1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 64'(vout[0]), 64'd0);
    chk("post_rst_ready", 64'(rout[0]), 64'd1);
    @(posedge clk);
    #1;

    // Directed carry / wrap / overflow / borrow cases at every width
    for (int d = 0; d < 3; d++) begin
      mask32 = (NW[d] == 32) ? 32'hFFFF_FFFF : (32'd1 << NW[d]) - 1;
      half   = (32'd1 << (NW[d] / 2)) - 1;
      mn     = 32'd1 << (NW[d] - 1);
      mx     = mn - 1;
      directed(d, half, 32'd1, 1'b0, {2'b00, half + 32'd1});
      directed(d, mask32, 32'd1, 1'b0, {2'b01, 32'h0});
      directed(d, mx, 32'd1, 1'b0, {2'b10, mn});
      directed(d, 32'd5, 32'd7, 1'b1, {2'b00, mask32 - 32'd1});
      directed(d, mn, 32'd1, 1'b1, {2'b11, mx});
    end
    directed(0, 32'h00FF, 32'h0001, 1'b0, {2'b00, 32'h0100});
    directed(0, 32'h8000, 32'h0001, 1'b1, {2'b11, 32'h7FFF});

    // Back-to-back stream with a 3-cycle sink stall
    base = deliv[0];
    fork
      begin
        for (int i = 0; i < 8; i++) send(0, 32'(i), 32'(i) * 32'h1000, 1'(i % 2), acc);
      end
      begin
        int k = 0;
        @(negedge clk);
        while (!vout[0] && k < 50) begin
          @(negedge clk);
          k++;
        end
        @(posedge clk);
        #1;
        rin[0] = 1'b0;
        cap = '0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk("stall_ready_out", 64'(rout[0]), 64'd0);
          chk("stall_valid_out", 64'(vout[0]), 64'd1);
          if (j == 0) cap = {ovf[0], cout[0], sum_w[0]};
          else chk("stall_stable", 64'({ovf[0], cout[0], sum_w[0]}), 64'(cap));
          @(posedge clk);
          #1;
        end
        rin[0] = 1'b1;
      end
    join
    drain(0);
    chk("stream_count", 64'(deliv[0] - base), 64'd8);

    // Reset with three beats in flight
    base = deliv[0];
    for (int i = 0; i < 3; i++) send(0, $urandom, $urandom, 1'b0, acc);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("flush_valid_out", 64'(vout[0]), 64'd0);
    end
    @(posedge clk);
    #1;
    send(0, 32'h1234, 32'h1111, 1'b0, acc);
    drain(0);
    chk("flush_count", 64'(deliv[0] - base), 64'd1);

    // Randomized operands, sub_in and sink backpressure
    random_run(0, 10000);
    random_run(1, 2000);
    random_run(2, 2000);

    for (int d = 0; d < 3; d++) chk($sformatf("dut%0d_final_empty", d), 64'(qsize(d)), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/arith_pipe_nbit.md
# arith_pipe_nbit

Pipelined, parametrised N-bit adder/subtractor with valid/ready flow control. The carry chain is split into STAGES equal segments, one register stage per segment, so wide operands close timing at full clock rate. It also reports carry/borrow and signed overflow. It sits between an operand source and a result sink on the datapath, and replaces the single-cycle combinational N-bit adder wherever operand width or clock rate calls for pipelining.

## Interface
- N, default 16: operand and result width in bits. Must be ≥ 2.
- STAGES, default 4: number of pipeline stages. Must satisfy 1 ≤ STAGES ≤ N with N % STAGES == 0. Segment width is W = N/STAGES.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- valid_in  input  1  operand beat valid.
- ready_out  output  1  block can accept a beat this cycle.
- a_in  input  N  operand A.
- b_in  input  N  operand B.
- sub_in  input  1  0 = A+B, 1 = A−B; sampled together with the operands.
- valid_out  output  1  result beat valid.
- ready_in  input  1  sink accepts the result this cycle.
- sum_out  output  N  result, modulo 2^N.
- carry_out  output  1  carry out of bit N−1. In subtract mode, 1 means no borrow (A ≥ B unsigned).
- ovf_out  output  1  two's-complement signed overflow.

## Operation
- Subtract is implemented as A + ~B + 1: B is inverted and the stage-0 carry-in is set to sub_in.
- Stage k (0..STAGES−1) adds segment k of A and B (bits [kW+W−1 : kW]) plus the carry registered by stage k−1.
  - Stage k registers: the result segment, its carry-out, the already-computed lower result segments, the still-unprocessed upper operand segments (B already inverted), and a valid bit.
- ovf_out = carry into bit N−1 XOR carry out of bit N−1. It is computed in the last stage and registered with the result.
- All of sum_out, carry_out, ovf_out and valid_out come from the last-stage register. No combinational path exists from a_in, b_in or sub_in to any output.
- Flow control uses one global enable: en = ready_in | ~valid_out, and ready_out = en.
  - When en = 0, every stage register holds, including its valid bit.
  - Bubbles are not compressed. A stalled pipeline holds its bubbles in place.
- A beat is accepted when valid_in & ready_out. It is delivered when valid_out & ready_in.
- Beats leave in acceptance order. None are dropped or duplicated.
- While valid_out = 1 and ready_in = 0, sum_out, carry_out and ovf_out remain stable.
- Operand and sub_in values presented while valid_in = 0 are ignored. The stage-0 valid bit is loaded with 0.

## Timing
- Reset (async assert): all valid bits, data and carry registers clear to 0.
  - Outputs during reset and after release: valid_out=0, sum_out=0, carry_out=0, ovf_out=0, ready_out=1.
- Reset asserted mid-operation discards every in-flight beat immediately. No result for those beats is ever presented.
- Latency: a beat accepted at rising edge t appears on valid_out after edge t+STAGES−1, i.e. visible in the cycle following that edge. Each stall cycle adds one cycle.
  - STAGES=1 degenerates to one registered adder with latency 1.
- Throughput: one beat per cycle while ready_in = 1.
- Simultaneous accept and deliver in the same cycle is legal and is the normal streaming case.
- With ready_in = 0 and the pipeline holding a valid output, ready_out = 0 in the same cycle. This is a combinational path ready_in → ready_out.
- Wrap-around: the result is always modulo 2^N. Overflow is reported only through carry_out and ovf_out; the result is never saturated.

## Test plan
Parameters N=16, STAGES=4 unless stated.

1. Add, carry across segments: 0x00FF + 0x0001, sub_in=0 → sum_out=0x0100, carry_out=0, ovf_out=0, exactly STAGES cycles after acceptance.
2. Add wrap and overflow:
   - 0xFFFF + 0x0001 → 0x0000, carry_out=1, ovf_out=0.
   - 0x7FFF + 0x0001 → 0x8000, carry_out=0, ovf_out=1.
3. Subtract:
   - 0x0005 − 0x0007 → 0xFFFE, carry_out=0 (borrow), ovf_out=0.
   - 0x8000 − 0x0001 → 0x7FFF, carry_out=1, ovf_out=1.
4. Backpressure: stream 8 back-to-back beats (A=i, B=0x1000·i, alternating sub_in), and drop ready_in for 3 cycles once the first result appears.
   - All 8 results arrive in order with correct values.
   - Outputs stay stable during the stall.
   - ready_out = 0 throughout the stall.
   - Nothing is lost or duplicated.
5. Reset mid-stream: accept 3 beats, assert rst for 1 cycle before any result emerges → valid_out stays 0 from the reset onward. A beat accepted after release is the first and only result delivered.
6. Parameter sweep:
   - Rerun scenarios 1–3 with N=8, STAGES=1 (latency 1) and with N=32, STAGES=8 (latency 8).
   - Compare against a reference model over 10k random operand/sub_in beats with random ready_in.
